// File: rtl/pipe_ctrl.sv
// Decode-stage sequencing controller: tracks in-flight destinations and
// produces decode hold, EX bubble and fetch/decode flush controls.
module pipe_ctrl #(
  parameter int DEPTH        = 3,
  parameter int FORWARD      = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        req,
  input  logic        reset,
  input  logic        instr_valid_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic        rs1_used_in,
  input  logic        rs2_used_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic        mem_read_in,
  input  logic        branch_taken_in,
  output logic        stall_out,
  output logic        bubble_out,
  output logic        flush_out,
  output logic [1:0]  state_out,
  output logic [15:0] stall_count_out
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  entry_t [DEPTH-1:0] sb;
  entry_t [DEPTH-1:0] sb_next;
  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_next;
  logic [15:0]        stall_count;
  logic               hazard;
  logic               hazard_shift;
  logic               flush_now;
  logic               stall;
  logic               bubble;

  function automatic logic src_match(input logic used, input logic [4:0] s,
                                     input entry_t e);
    return used && (s != 5'd0) && e.v && (e.rd == s);
  endfunction

  // With forwarding only a load sitting in EX can hold decode.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((FORWARD == 0) || (k == 0 && sb[k].ld)) begin
        if (src_match(rs1_used_in, rs1_in, sb[k]) ||
            src_match(rs2_used_in, rs2_in, sb[k]))
          hazard = 1'b1;
      end
    end
    hazard = hazard && instr_valid_in;
  end

  assign flush_now = branch_taken_in || (state == FLUSH);
  assign stall     = hazard && !flush_now;
  assign bubble    = stall || flush_now;

  always_comb begin
    sb_next = sb;
    for (int k = DEPTH - 1; k > 0; k--)
      sb_next[k] = sb[k-1];
    if (bubble) begin
      sb_next[0] = '0;
    end else begin
      sb_next[0].v  = instr_valid_in && rd_write_in && (rd_in != 5'd0);
      sb_next[0].rd = rd_in;
      sb_next[0].ld = mem_read_in;
    end
  end

  // Hazard the held decode instruction would still see once the pipe advances.
  always_comb begin
    hazard_shift = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((FORWARD == 0) || (k == 0 && sb_next[k].ld)) begin
        if (src_match(rs1_used_in, rs1_in, sb_next[k]) ||
            src_match(rs2_used_in, rs2_in, sb_next[k]))
          hazard_shift = 1'b1;
      end
    end
    hazard_shift = hazard_shift && instr_valid_in;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      RUN: begin
        if (branch_taken_in) begin
          state_next = FLUSH;
          cnt_next   = FLUSH_LOAD;
        end else if (stall) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (branch_taken_in) begin
          state_next = FLUSH;
          cnt_next   = FLUSH_LOAD;
        end else if (!(stall && hazard_shift)) begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        if (branch_taken_in)
          cnt_next = FLUSH_LOAD;
        else if (cnt == '0)
          state_next = RUN;
        else
          cnt_next = cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      sb          <= '0;
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      sb    <= sb_next;
      state <= state_next;
      cnt   <= cnt_next;
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

  assign stall_out       = stall;
  assign bubble_out      = bubble;
  assign flush_out       = flush_now;
  assign state_out       = state;
  assign stall_count_out = stall_count;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the decode stage. It keeps a small scoreboard of in-flight destination registers. From that scoreboard and the branch-resolution signal it generates three controls:
- decode hold (drives decode's rs_read hold input),
- bubble injection into EX,
- decode/fetch flush (drives decode's reset input).
It also keeps a saturating stall-cycle performance counter.

Parameters:
DEPTH, 3, number of tracked stages after decode (EX, MEM, WB); entry 0 = EX.
FORWARD, 1, 1 = ALU results forwarded from EX/MEM/WB (only loads in entry 0 stall); 0 = no forwarding (any pending match stalls).
FLUSH_CYCLES, 2, cycles flush_out stays high after a taken branch (min 1).

Ports:
req  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
instr_valid_in  input  1  instruction in decode is valid
rs1_in  input  5  decode source register 1
rs2_in  input  5  decode source register 2
rs1_used_in  input  1  instruction reads rs1
rs2_used_in  input  1  instruction reads rs2
rd_in  input  5  decode destination register
rd_write_in  input  1  instruction writes rd
mem_read_in  input  1  instruction in decode is a load
branch_taken_in  input  1  taken branch/jump resolved in EX this cycle
stall_out  output  1  hold fetch and decode (drives decode rs_read)
bubble_out  output  1  inject invalid instruction into EX
flush_out  output  1  kill fetch/decode contents (drives decode reset)
state_out  output  2  00 RUN, 01 STALL, 10 FLUSH
stall_count_out  output  16  saturating count of stalled cycles

Behaviour:
- Scoreboard: DEPTH entries of {v, rd[4:0], ld}, all registered.
- Match on source s (rs1 or rs2): s_used && s != 0 && entry.v && entry.rd == s.
- hazard (combinational):
  - FORWARD=1: match against entry 0 with ld=1.
  - FORWARD=0: match against any entry.
  - Gated by instr_valid_in.
- flush_now = branch_taken_in || state == FLUSH.
- Outputs (combinational from inputs and registered state):
  - stall_out = hazard && !flush_now.
  - bubble_out = stall_out || flush_now.
  - flush_out = flush_now.
  - Flush has priority over stall.
- Scoreboard update on each posedge req:
  - Entry k moves to entry k+1; the last entry is dropped.
  - If bubble_out=1: entry 0 <= v=0.
  - Otherwise: entry 0 <= {instr_valid_in && rd_write_in && rd_in != 0, rd_in, mem_read_in}.
- FSM, registered, evaluated on each posedge req:
  - RUN, branch_taken_in -> FLUSH; flush counter <= FLUSH_CYCLES-1.
  - RUN, stall_out -> STALL.
  - RUN, otherwise -> stays RUN.
  - STALL, branch_taken_in -> FLUSH (load counter as above).
  - STALL, hazard still present after the shift -> stays STALL.
  - STALL, otherwise -> RUN.
  - FLUSH, counter == 0 -> RUN; else counter decrements.
  - FLUSH, a new branch_taken_in reloads the counter.
  - FLUSH_CYCLES=1: FLUSH lasts one cycle beyond the branch cycle.
  - state_out reflects the registered state; it lags stall_out by one cycle.
- Stall counter: stall_count_out increments on every posedge where stall_out=1, and saturates at 16'hFFFF (no wrap).
- Load-use latency: a load followed by a dependent instruction gives exactly 1 stall cycle when FORWARD=1.
- With FORWARD=0, a dependency stalls until the producer leaves entry DEPTH-1. For a producer directly ahead, that is DEPTH cycles.
- x0 never creates a hazard, whether as source or destination.
- Both sources matching different entries: hazard is the OR of both matches.
- Reset (asynchronous, any state, including mid-flush or mid-stall):
  - All scoreboard v=0, state RUN, counter 0, stall_count_out 0.
  - stall_out=0, bubble_out=0, flush_out=0 while reset is high and branch_taken_in=0.
- Deasserting reset resumes in RUN at the next edge.

Test Plan:
- Load-use hazard:
  - Stimulus: lw x5 (rd=5, mem_read=1), then add x6,x5,x1 (rs1=5 used).
  - Required: stall_out=1 and bubble_out=1 for 1 cycle; state_out=01 for 1 cycle; stall_count_out=1; add then issues.
- ALU dependency:
  - Stimulus: addi x7 then add using rs2=7.
  - FORWARD=1: stall_out stays 0.
  - FORWARD=0 (DEPTH=3): stall_out=1 for 3 cycles, then stall_count_out=3.
- x0 dependency:
  - Stimulus: producer with rd=0 (rd_write=1), consumer rs1=0.
  - Required: no stall; entry 0 v=0.
- Branch during stall:
  - Stimulus: load-use stall active and branch_taken_in=1 in the same cycle.
  - Required: stall_out=0, flush_out=1 that cycle plus 2 more (FLUSH_CYCLES=2); state_out=10 for 2 cycles, then 00; scoreboard entry 0 v=0.
- Reset mid-flush:
  - Stimulus: assert reset asynchronously in the second FLUSH cycle.
  - Required: flush_out drops immediately; state_out=00; stall_count_out=0; a subsequent load-use still stalls 1 cycle.
- Counter saturation:
  - Stimulus: preset or hold a hazard for more than 65535 cycles.
  - Required: stall_count_out holds at 16'hFFFF.
